// File: rtl/rr8_pkg.sv
// Shared definitions for the 8-client request front end.
// Holds the client count, the client index width and the two grant-vector
// helpers (one-hot test and one-hot to index encode).
package rr8_pkg;

  localparam int N_CLIENTS = 8;
  localparam int ID_W      = 3;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [N_CLIENTS-1:0] v);
    logic [N_CLIENTS-1:0] low_cleared;
    low_cleared = v & (v - 8'd1);
    return (v != 8'd0) && (low_cleared == 8'd0);
  endfunction

  // Encodes a one-hot vector to its bit index. The OR-reduction form gives a
  // meaningful result only for one-hot input; callers qualify with is_onehot.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N_CLIENTS-1:0] v);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = 0; i < N_CLIENTS; i++) begin
      idx = idx | (v[i] ? ID_W'(i) : {ID_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr8_client_fifo.sv
// Per-client FIFO of DEPTH entries.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   push, push_data   write request and payload (ignored when full)
//   pop               remove head (ignored when empty)
//   head              current head entry (valid when occ != 0)
//   occ               registered occupancy, log2(DEPTH)+1 bits
// Only pointers and occupancy are reset; storage is left as is.
module rr8_client_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = AW + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [OCC_W-1:0]  occ_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // Local guards keep the FIFO self-consistent even if a caller misbehaves.
  always_comb begin
    push_ok_s = push && (occ_r != FULL_OCC);
    pop_ok_s  = pop && (occ_r != {OCC_W{1'b0}});
  end

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Storage write port, no reset needed on the payload array.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head = mem_r[rd_ptr_r];
  assign occ  = occ_r;

endmodule

// File: rtl/rr8_req_frontend.sv
// Request front end for an 8-way round-robin arbiter.
// Each client pushes payloads into its own FIFO; a non-empty FIFO raises its
// req bit. A one-hot grant to a non-empty queue pops its head, which appears
// on out_data/out_id with a one-cycle out_valid pulse on the next cycle.
// Ports:
//   in_valid/in_ready/in_data  per-client push interface (8 x DATA_W payload)
//   req                        request vector to the arbiter (registered decode)
//   gnt                        arbiter grant, one-hot or zero expected
//   out_valid/out_data/out_id  granted payload, held while out_valid=0
//   stale_cnt                  saturating count of grants to empty queues
//   err_multi                  sticky multi-hot grant flag
module rr8_req_frontend
  import rr8_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_valid,
  output logic [7:0]            in_ready,
  input  logic [8*DATA_W-1:0]   in_data,
  output logic [7:0]            req,
  input  logic [7:0]            gnt,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [2:0]            out_id,
  output logic [7:0]            stale_cnt,
  output logic                  err_multi
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [DATA_W-1:0]      head_s [N_CLIENTS];
  logic [OCC_W-1:0]       occ_s  [N_CLIENTS];
  logic [N_CLIENTS-1:0]   push_s;
  logic [N_CLIENTS-1:0]   pop_s;
  logic                   gnt_onehot_s;
  logic [ID_W-1:0]        gnt_idx_s;
  logic                   gnt_hit_s;
  logic                   gnt_stale_s;
  logic                   gnt_multi_s;

  logic                   out_valid_r;
  logic [DATA_W-1:0]      out_data_r;
  logic [ID_W-1:0]        out_id_r;
  logic [7:0]             stale_cnt_r;
  logic                   err_multi_r;

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_client
    rr8_client_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s[i]),
      .push_data (in_data[i*DATA_W +: DATA_W]),
      .pop       (pop_s[i]),
      .head      (head_s[i]),
      .occ       (occ_s[i])
    );

    // Both handshake signals come straight from registered occupancy, so a
    // same-cycle pop never frees space for a push.
    assign in_ready[i] = (occ_s[i] < FULL_OCC);
    assign req[i]      = (occ_s[i] != {OCC_W{1'b0}});
  end

  assign push_s = in_valid & in_ready;

  // Grant classification: valid pop, stale (empty target) or multi-hot.
  always_comb begin
    gnt_onehot_s = is_onehot(gnt);
    gnt_idx_s    = onehot_to_idx(gnt);
    if (gnt_onehot_s) begin
      gnt_hit_s   = req[gnt_idx_s];
      gnt_stale_s = !req[gnt_idx_s];
    end else begin
      gnt_hit_s   = 1'b0;
      gnt_stale_s = 1'b0;
    end
    gnt_multi_s = (gnt != 8'd0) && !gnt_onehot_s;
    pop_s       = gnt_hit_s ? gnt : 8'd0;
  end

  // Output register, stale counter and sticky multi-hot flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_id_r    <= {ID_W{1'b0}};
      stale_cnt_r <= 8'd0;
      err_multi_r <= 1'b0;
    end else begin
      out_valid_r <= gnt_hit_s;
      if (gnt_hit_s) begin
        out_data_r <= head_s[gnt_idx_s];
        out_id_r   <= gnt_idx_s;
      end
      if (gnt_stale_s && (stale_cnt_r != 8'hFF)) begin
        stale_cnt_r <= stale_cnt_r + 8'd1;
      end
      if (gnt_multi_s) begin
        err_multi_r <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_id    = out_id_r;
  assign stale_cnt = stale_cnt_r;
  assign err_multi = err_multi_r;

endmodule

// File: tb/tb_rr8_req_frontend.sv
// Self-checking bench for rr8_req_frontend (DATA_W=16, DEPTH=4).
// A queue-based model tracks per-client contents, the expected output pulse,
// the stale count and the multi-hot flag from the grant/push rules.
module tb_rr8_req_frontend;

  localparam int DW  = 16;
  localparam int DEP = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       in_valid;
  logic [7:0]       in_ready;
  logic [8*DW-1:0]  in_data;
  logic [7:0]       req;
  logic [7:0]       gnt;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [2:0]       out_id;
  logic [7:0]       stale_cnt;
  logic             err_multi;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [DW-1:0] mq [8][$];
  logic          m_out_valid;
  logic [DW-1:0] m_out_data;
  logic [2:0]    m_out_id;
  int            m_stale;
  logic          m_err;

  rr8_req_frontend #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .stale_cnt (stale_cnt),
    .err_multi (err_multi)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_req();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  function automatic logic [7:0] exp_ready();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (mq[i].size() < DEP);
    return r;
  endfunction

  // Apply current inputs for one clock edge and advance the model to match.
  task automatic cycle();
    int sz [8];
    int ones;
    int idx;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mq[i].delete();
      m_out_valid = 1'b0;
      m_out_data  = '0;
      m_out_id    = '0;
      m_stale     = 0;
      m_err       = 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) sz[i] = mq[i].size();
      ones = $countones(gnt);
      idx  = 0;
      for (int i = 0; i < 8; i++) if (gnt[i]) idx = i;
      m_out_valid = 1'b0;
      if (ones == 1) begin
        if (sz[idx] > 0) begin
          m_out_valid = 1'b1;
          m_out_data  = mq[idx].pop_front();
          m_out_id    = 3'(idx);
        end else if (m_stale < 255) begin
          m_stale++;
        end
      end else if (ones > 1) begin
        m_err = 1'b1;
      end
      for (int i = 0; i < 8; i++)
        if (in_valid[i] && sz[i] < DEP) mq[i].push_back(in_data[i*DW +: DW]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 8'd0; gnt = 8'd0; in_data = '0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (req !== 8'h00) $display("FAIL reset_req got %h want 00", req); else n_pass++;
    n_checks++; if (in_ready !== 8'hFF) $display("FAIL reset_ready got %h want ff", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'h0000 || out_id !== 3'd0) $display("FAIL reset_out got %h/%0d want 0/0", out_data, out_id); else n_pass++;
    n_checks++; if (stale_cnt !== 8'd0 || err_multi !== 1'b0) $display("FAIL reset_err got %0d/%b want 0/0", stale_cnt, err_multi); else n_pass++;
  endtask

  task automatic test_basic();
    in_data = '0; in_data[3*DW +: DW] = 16'hA5A5; in_valid = 8'h08;
    cycle();
    in_valid = 8'h00;
    n_checks++; if (req !== 8'h08) $display("FAIL basic_req got %h want 08", req); else n_pass++;
    gnt = 8'h08;
    cycle();
    gnt = 8'h00;
    n_checks++; if (out_valid !== 1'b1 || out_id !== 3'd3 || out_data !== 16'hA5A5)
      $display("FAIL basic_out got v=%b id=%0d d=%h want 1/3/a5a5", out_valid, out_id, out_data); else n_pass++;
    n_checks++; if (req !== 8'h00) $display("FAIL basic_req_drop got %h want 00", req); else n_pass++;
    cycle();
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'hA5A5 || out_id !== 3'd3)
      $display("FAIL basic_hold got v=%b id=%0d d=%h want 0/3/a5a5", out_valid, out_id, out_data); else n_pass++;
  endtask

  task automatic test_full();
    in_data = '0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        n_checks++; if (in_ready[0] !== 1'b0) $display("FAIL full_ready got %b want 0", in_ready[0]); else n_pass++;
      end
      in_valid = 8'h01; in_data[DW-1:0] = 16'h0100 + 16'(k);
      cycle();
    end
    in_valid = 8'h00;
    for (int k = 0; k < 4; k++) begin
      gnt = 8'h01;
      cycle();
      gnt = 8'h00;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h0100 + 16'(k))
        $display("FAIL full_order%0d got v=%b d=%h want 1/%h", k, out_valid, out_data, 16'h0100 + 16'(k)); else n_pass++;
      if (k == 0) begin
        n_checks++; if (in_ready[0] !== 1'b1) $display("FAIL full_ready_after_pop got %b want 1", in_ready[0]); else n_pass++;
      end
    end
    n_checks++; if (req[0] !== 1'b0) $display("FAIL full_drop5 req0 got %b want 0", req[0]); else n_pass++;
  endtask

  task automatic test_stale();
    int pulses;
    apply_reset();
    in_data = '0; in_data[5*DW +: DW] = 16'h5555; in_valid = 8'h20;
    cycle();
    in_valid = 8'h00; pulses = 0;
    gnt = 8'h20; cycle(); if (out_valid === 1'b1) pulses++;
    gnt = 8'h20; cycle(); if (out_valid === 1'b1) pulses++;
    gnt = 8'h00; cycle(); if (out_valid === 1'b1) pulses++;
    n_checks++; if (pulses != 1) $display("FAIL stale_pulses got %0d want 1", pulses); else n_pass++;
    n_checks++; if (stale_cnt !== 8'd1) $display("FAIL stale_cnt got %0d want 1", stale_cnt); else n_pass++;
  endtask

  task automatic test_multi();
    in_data = '0; in_data[DW-1:0] = 16'h0A0A; in_data[4*DW +: DW] = 16'h4B4B; in_valid = 8'h11;
    cycle();
    in_valid = 8'h00; gnt = 8'h11;
    cycle();
    gnt = 8'h00;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL multi_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (err_multi !== 1'b1) $display("FAIL multi_err got %b want 1", err_multi); else n_pass++;
    n_checks++; if (req !== 8'h11) $display("FAIL multi_req got %h want 11", req); else n_pass++;
    gnt = 8'h10; cycle(); gnt = 8'h00;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h4B4B || out_id !== 3'd4)
      $display("FAIL multi_keep got v=%b id=%0d d=%h want 1/4/4b4b", out_valid, out_id, out_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    in_data = {8{16'h1234}}; in_valid = 8'h06;
    cycle(); cycle();
    in_valid = 8'h00; gnt = 8'h02; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; gnt = 8'h00;
    n_checks++; if (out_valid !== 1'b0 || req !== 8'h00 || in_ready !== 8'hFF)
      $display("FAIL rstmid got v=%b req=%h rdy=%h want 0/00/ff", out_valid, req, in_ready); else n_pass++;
    cycle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_after got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_random();
    int a, b, r;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      in_valid = 8'($urandom);
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 7);
      b = (a + 1 + $urandom_range(0, 6)) % 8;
      if (r < 4) gnt = 8'h00;
      else if (r < 9) gnt = 8'h01 << a;
      else gnt = (8'h01 << a) | (8'h01 << b);
      cycle();
      n_checks++; if (out_valid !== m_out_valid) $display("FAIL rnd_valid c%0d got %b want %b", c, out_valid, m_out_valid); else n_pass++;
      n_checks++; if (out_data !== m_out_data || out_id !== m_out_id)
        $display("FAIL rnd_out c%0d got %h/%0d want %h/%0d", c, out_data, out_id, m_out_data, m_out_id); else n_pass++;
      n_checks++; if (req !== exp_req() || in_ready !== exp_ready())
        $display("FAIL rnd_req c%0d got %h/%h want %h/%h", c, req, in_ready, exp_req(), exp_ready()); else n_pass++;
      n_checks++; if (stale_cnt !== 8'(m_stale) || err_multi !== m_err)
        $display("FAIL rnd_err c%0d got %0d/%b want %0d/%b", c, stale_cnt, err_multi, m_stale, m_err); else n_pass++;
    end
    rst_n = 1'b1;
  endtask

  // Round-robin arbiter with two-cycle grant latency, all clients fed.
  task automatic test_rr_fairness();
    logic [7:0] pipe0, pipe1, ng;
    int last, cand, seen_mask;
    int win[$];
    apply_reset();
    pipe0 = 8'h00; pipe1 = 8'h00; last = 7;
    for (int c = 0; c < 200; c++) begin
      in_valid = 8'hFF;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      gnt = pipe1;
      ng  = 8'h00;
      for (int k = 1; k <= 8; k++) begin
        cand = (last + k) % 8;
        if (ng == 8'h00 && req[cand]) begin
          ng = 8'h01 << cand;
          last = cand;
        end
      end
      pipe1 = pipe0; pipe0 = ng;
      cycle();
      n_checks++; if (out_valid !== m_out_valid || (m_out_valid && (out_data !== m_out_data || out_id !== m_out_id)))
        $display("FAIL rr_out c%0d got %b/%h/%0d want %b/%h/%0d", c, out_valid, out_data, out_id, m_out_valid, m_out_data, m_out_id); else n_pass++;
      if (out_valid === 1'b1) begin
        win.push_back(int'(out_id));
        if (win.size() > 8) void'(win.pop_front());
        if (win.size() == 8) begin
          seen_mask = 0;
          foreach (win[j]) seen_mask |= (1 << win[j]);
          n_checks++; if (seen_mask != 255) $display("FAIL rr_window c%0d got mask %h want ff", c, seen_mask); else n_pass++;
        end
      end
    end
    n_checks++; if (err_multi !== 1'b0 || stale_cnt !== 8'(m_stale))
      $display("FAIL rr_err got %b/%0d want 0/%0d", err_multi, stale_cnt, m_stale); else n_pass++;
    in_valid = 8'h00; gnt = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 8'd0; gnt = 8'd0; in_data = '0;
    test_reset();
    test_basic();
    test_full();
    test_stale();
    test_multi();
    test_reset_mid();
    test_random();
    test_rr_fairness();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr8_req_frontend.md
RR8_REQ_FRONTEND -- requirements
Module: rr8_req_frontend

Interface
REQ-001 Parameter DATA_W, default 16, payload width per client.
REQ-002 Parameter DEPTH, default 4, per-client queue depth in entries; power of two, at least 2.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  8  per-client push request.
REQ-006 in_ready  output  8  per-client queue not full.
REQ-007 in_data  input  8*DATA_W  client i payload in bits [i*DATA_W +: DATA_W].
REQ-008 req  output  8  request vector to the 8-way round-robin arbiter.
REQ-009 gnt  input  8  arbiter grant, expected one-hot or zero, arbitrary pipeline latency.
REQ-010 out_valid  output  1  granted payload valid, single-cycle pulse.
REQ-011 out_data  output  DATA_W  granted payload.
REQ-012 out_id  output  3  index of the granted client.
REQ-013 stale_cnt  output  8  saturating count of grants to an empty queue.
REQ-014 err_multi  output  1  sticky flag for a multi-hot grant.

Function
REQ-015 Each client owns a FIFO of DEPTH entries; a push occurs when in_valid[i] and in_ready[i] are both high.
REQ-016 in_ready[i] = occupancy[i] < DEPTH, decoded from registers only; a push is refused when full even if a pop occurs in the same cycle.
REQ-017 req[i] = occupancy[i] != 0, decoded from registered occupancy only; there is no combinational path from gnt or in_valid to req.
REQ-018 A valid grant is gnt one-hot with occupancy[i] != 0; it pops the head of queue i in the same cycle.
REQ-019 Following a valid grant at cycle t, at cycle t+1 out_valid=1, out_data=the popped head, and out_id=i; out_valid is 0 in every other cycle.
REQ-020 out_data and out_id hold their last values while out_valid=0.
REQ-021 A simultaneous push and pop on the same queue keeps occupancy unchanged; the pushed entry goes to the tail and FIFO order is preserved.
REQ-022 A push into an empty queue raises req[i] at t+1; a pop of the last entry drops req[i] at t+1.
REQ-023 Stale grant: one-hot gnt to an empty queue causes no pop and no out_valid, and increments stale_cnt by 1, saturating at 255.
REQ-024 Multi-hot gnt (two or more bits set) causes no pop and no out_valid, and sets err_multi=1 until reset.
REQ-025 gnt=0 is a no-op.
REQ-026 Read and write pointers wrap modulo DEPTH; occupancy is held in log2(DEPTH)+1 bits.
REQ-027 out_valid does not accept backpressure; the downstream sink accepts every pulse.

Reset
REQ-028 While rst_n=0 at a clock edge, all queues are emptied, pointers cleared, and the following values apply at the next edge: req=0, in_ready=8'hFF, out_valid=0, out_data=0, out_id=0, stale_cnt=0, err_multi=0.
REQ-029 Reset asserted mid-operation discards all queued entries and any grant presented in that cycle; no out_valid pulse follows.
REQ-030 Queue RAM contents do not need reset; only pointers and occupancy are reset.

Structure
REQ-031 Shared package rr8_pkg holds N_CLIENTS=8, ID_W=3, the onehot-to-index function, and the is-onehot function.
REQ-032 Sub-module rr8_client_fifo is instantiated 8 times (push/pop/head/occupancy); the top level holds grant decode, output register, and error counters.
REQ-033 Target implementation size is 120-400 lines of RTL total.

Verification
REQ-034 Reset, then push 16'hA5A5 to client 3 -> req=8'h08 one cycle later; drive gnt=8'h08 -> next cycle out_valid=1, out_id=3, out_data=16'hA5A5, then req=8'h00.
REQ-035 Push 4 entries to client 0, attempt a 5th push -> in_ready[0]=0 and the 5th push is dropped; 4 grants return the data in push order, and in_ready[0]=1 after the first pop.
REQ-036 Client 5 holds 1 entry; gnt=8'h20 on two consecutive cycles -> exactly one out_valid and stale_cnt=1.
REQ-037 gnt=8'h11 with queues 0 and 4 non-empty -> no out_valid, err_multi=1, occupancies unchanged.
REQ-038 Connect to rr8_tree_pipelined with all 8 clients continuously fed -> every client is served within any 8 consecutive out_valid pulses, and gnt is always one-hot or zero.
REQ-039 Assert rst_n=0 in the same cycle as a valid grant while queues are partially full -> next cycle out_valid=0, req=0, in_ready=8'hFF.
